// File: rtl/multiplexor_display.sv
// Purpose: time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
// Latency: anodo/segmentos/digito/frame_tick are registered one cycle after the cnt/dig that select them.
// Backpressure: none; free-running scan, enable=0 blanks the display and parks the scan at frame start.
module multiplexor_display #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] catodo1,
    input  logic [7:0] catodo2,
    input  logic [7:0] catodo3,
    input  logic [7:0] catodo4,
    output logic [3:0] anodo,
    output logic [7:0] segmentos,
    output logic [1:0] digito,
    output logic       frame_tick
);

    localparam int              CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   BLANK_LIM = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    dig;
    logic [7:0]    sh0, sh1, sh2, sh3;
    logic [7:0]    sel_pat;
    logic          slot_end;
    logic          frame_start;
    logic          in_blank;

    // Pick the shadowed pattern belonging to the current slot.
    always_comb begin
        sel_pat = sh0;
        case (dig)
            2'd1:    sel_pat = sh1;
            2'd2:    sel_pat = sh2;
            2'd3:    sel_pat = sh3;
            default: sel_pat = sh0;
        endcase
    end

    assign slot_end    = (cnt == CNT_MAX);
    assign frame_start = (cnt == '0) && (dig == 2'd0);
    assign in_blank    = (cnt < BLANK_LIM);

    // Scan counters, frame-latched shadows and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            dig        <= 2'd0;
            sh0        <= 8'hFF;
            sh1        <= 8'hFF;
            sh2        <= 8'hFF;
            sh3        <= 8'hFF;
            anodo      <= 4'b1111;
            segmentos  <= 8'hFF;
            digito     <= 2'd0;
            frame_tick <= 1'b0;
        end else if (!enable) begin
            // Park at frame start so re-enabling begins with a fresh latch.
            cnt        <= '0;
            dig        <= 2'd0;
            anodo      <= 4'b1111;
            segmentos  <= 8'hFF;
            digito     <= 2'd0;
            frame_tick <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                dig <= dig + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            // Latch all four digits together so a frame never mixes old and new data.
            if (frame_start) begin
                sh0        <= catodo1;
                sh1        <= catodo2;
                sh2        <= catodo3;
                sh3        <= catodo4;
                frame_tick <= 1'b1;
            end else begin
                frame_tick <= 1'b0;
            end

            // Blank the head of every slot so the previous digit's segments never ghost.
            if (in_blank) begin
                anodo     <= 4'b1111;
                segmentos <= 8'hFF;
            end else begin
                anodo     <= ~(4'b0001 << dig);
                segmentos <= sel_pat;
            end
            digito <= dig;
        end
    end

endmodule

// File: tb/tb_multiplexor_display.sv
// Purpose: directed self-checking bench for multiplexor_display with REFRESH_DIV=8, BLANK_CYCLES=2.
// Latency: outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: not applicable; the bench steps the free-running scan edge by edge.
module tb_multiplexor_display;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] catodo1, catodo2, catodo3, catodo4;
    logic [3:0] anodo;
    logic [7:0] segmentos;
    logic [1:0] digito;
    logic       frame_tick;

    int n_chk  = 0;
    int n_pass = 0;

    multiplexor_display #(
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .catodo1   (catodo1),
        .catodo2   (catodo2),
        .catodo3   (catodo3),
        .catodo4   (catodo4),
        .anodo     (anodo),
        .segmentos (segmentos),
        .digito    (digito),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_anodo"}, 32'(anodo), 32'h F);
        chk({tag, "_seg"}, 32'(segmentos), 32'h FF);
        chk({tag, "_digito"}, 32'(digito), 32'h0);
        chk({tag, "_tick"}, 32'(frame_tick), 32'h0);
    endtask

    task automatic set_pats();
        catodo1 = 8'h03;
        catodo2 = 8'h9F;
        catodo3 = 8'h25;
        catodo4 = 8'h0D;
    endtask

    initial begin
        logic [7:0] pat [4];
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        logic [3:0] prev_an;
        int         slot, c, blank_run;

        reset  = 1'b1;
        enable = 1'b1;
        set_pats();

        // 1. Reset state held over 3 edges.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_dark("reset");
        end

        // 2/3. Scan order over two frames; catodo3 changes during frame 0, digit 1.
        reset = 1'b0;
        for (int e = 1; e <= 64; e++) begin
            step();
            slot = ((e - 1) / 8) % 4;
            c    = (e - 1) % 8;
            pat  = '{8'h03, 8'h9F, 8'h25, 8'h0D};
            if (e > 32) pat[2] = 8'h01;
            exp_an  = (c < 2) ? 4'b1111 : ~(4'b0001 << slot);
            exp_seg = (c < 2) ? 8'hFF : pat[slot];
            chk($sformatf("scan_e%0d_anodo", e), 32'(anodo), 32'(exp_an));
            chk($sformatf("scan_e%0d_seg", e), 32'(segmentos), 32'(exp_seg));
            chk($sformatf("scan_e%0d_digito", e), 32'(digito), 32'(slot));
            chk($sformatf("scan_e%0d_tick", e), 32'(frame_tick), 32'(c == 0 && slot == 0));
            if (e == 12) catodo3 = 8'h01;
        end

        // 4. Enable drop mid-slot, then re-enable with new data.
        set_pats();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int e = 1; e <= 20; e++) step();
        chk("en_e20_anodo", 32'(anodo), 32'h B);
        chk("en_e20_seg", 32'(segmentos), 32'h25);
        chk("en_e20_digito", 32'(digito), 32'h2);
        enable  = 1'b0;
        catodo1 = 8'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_dark("disabled");
        end
        enable = 1'b1;
        step();
        chk("reen_tick", 32'(frame_tick), 32'h1);
        chk("reen_blank0", 32'(anodo), 32'h F);
        step();
        chk("reen_tick_low", 32'(frame_tick), 32'h0);
        chk("reen_blank1", 32'(anodo), 32'h F);
        step();
        chk("reen_lit_anodo", 32'(anodo), 32'h E);
        chk("reen_lit_seg", 32'(segmentos), 32'h55);

        // 5. Reset while digit 3 is shown.
        set_pats();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int e = 1; e <= 27; e++) step();
        chk("mid_e27_anodo", 32'(anodo), 32'h7);
        chk("mid_e27_seg", 32'(segmentos), 32'h0D);
        reset = 1'b1;
        step();
        chk_dark("mid_reset");
        chk("mid_sh0", 32'(dut.sh0), 32'h FF);
        chk("mid_sh1", 32'(dut.sh1), 32'h FF);
        chk("mid_sh2", 32'(dut.sh2), 32'h FF);
        chk("mid_sh3", 32'(dut.sh3), 32'h FF);
        reset = 1'b0;
        step();
        chk("restart_tick", 32'(frame_tick), 32'h1);
        chk("restart_blank", 32'(anodo), 32'h F);
        step();
        step();
        chk("restart_anodo", 32'(anodo), 32'h E);
        chk("restart_seg", 32'(segmentos), 32'h03);

        // 6. Invariants under random inputs: one-hot-low anodes, 2 blank cycles between digits.
        prev_an   = anodo;
        blank_run = 0;
        for (int i = 0; i < 200; i++) begin
            catodo1 = 8'($urandom);
            catodo2 = 8'($urandom);
            catodo3 = 8'($urandom);
            catodo4 = 8'($urandom);
            step();
            chk("inv_anodo_legal", 32'(anodo inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7}), 32'h1);
            if (anodo == 4'hF) begin
                blank_run++;
            end else begin
                if (prev_an == 4'hF) chk("inv_blank_run", 32'(blank_run), 32'h2);
                else chk("inv_no_direct_switch", 32'(anodo), 32'(prev_an));
                blank_run = 0;
            end
            prev_an = anodo;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multiplexor_display.md
Name: multiplexor_display

Overview:
- Time-multiplexed scan driver for the 4-digit, common-anode 7-segment display.
- Sits directly downstream of the cathode-pattern decoder and consumes its four 8-bit active-low patterns (catodo1..catodo4).
- Drives one shared segment bus plus four active-low anode enables.
- Latches all four patterns once per frame, so a mid-frame change in the decoder inputs never tears the display.
- Inserts a blanking interval at the start of every digit slot to suppress ghosting.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot (frame = 4*REFRESH_DIV cycles). Legal range >= 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off. Legal range 1 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = scan running; 0 = display dark, scan held at frame start
- catodo1  in  8  pattern for digit 0, active-low, bit7..1 = segments a..g, bit0 = dp
- catodo2  in  8  pattern for digit 1
- catodo3  in  8  pattern for digit 2
- catodo4  in  8  pattern for digit 3
- anodo  out  4  active-low anode enables; anodo[i] low lights digit i
- segmentos  out  8  active-low segment bus, same bit order as catodoN
- digito  out  2  index of the slot the current outputs belong to
- frame_tick  out  1  one-cycle pulse marking a frame-latch event

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. It is sampled only on the rising edge of clk.
- Internal state:
  - cnt: 0..REFRESH_DIV-1, width clog2(REFRESH_DIV).
  - dig: 2 bits.
  - sh0..sh3: 8-bit shadow registers.
- Reset values: cnt=0, dig=0, sh0..sh3=8'hFF, anodo=4'b1111, segmentos=8'hFF, digito=0, frame_tick=0.
- Reset has priority over enable. Reset asserted mid-frame yields the reset values at the next edge; the scan restarts from slot 0.
- enable=0, each edge:
  - cnt<=0, dig<=0, anodo<=4'b1111, segmentos<=8'hFF, digito<=0, frame_tick<=0.
  - Shadows hold.
- enable=1, each edge, counters:
  - If cnt==REFRESH_DIV-1: cnt<=0 and dig<=dig+1, wrapping 3->0.
  - Else cnt<=cnt+1.
- enable=1, each edge, frame latch:
  - If cnt==0 and dig==0: sh0<=catodo1, sh1<=catodo2, sh2<=catodo3, sh3<=catodo4, and frame_tick<=1.
  - Else frame_tick<=0.
- enable=1, each edge, outputs (registered from the pre-edge cnt/dig; one-cycle latency):
  - If cnt<BLANK_CYCLES: anodo<=4'b1111 and segmentos<=8'hFF.
  - Else anodo<=~(4'b0001<<dig) and segmentos<=sh[dig].
  - digito<=dig in both cases.
- Because BLANK_CYCLES>=1, a freshly latched shadow is never displayed in the cycle it is written.
- At most one anodo bit is low in any cycle. Transitions between digits always pass through 4'b1111.
- Input changes after the frame latch are invisible until the next frame latch (next cnt==0, dig==0).
- After enable rises, the first enabled edge is a frame latch, so a new frame always starts with fresh data.
- Display map: digit0<-catodo1 (anodo=4'b1110), digit1<-catodo2 (4'b1101), digit2<-catodo3 (4'b1011), digit3<-catodo4 (4'b0111).

Test Plan:
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2.

1. Reset state: hold reset=1 with enable=1 for 3 edges -> anodo=4'b1111, segmentos=8'hFF, digito=0, frame_tick=0.
2. Scan order:
   - Stimulus: release reset with catodo1..4 = 8'h03, 8'h9F, 8'h25, 8'h0D and enable=1.
   - Edge 1: frame_tick=1.
   - Edges 1-2: anodo=4'b1111.
   - Edges 3-8: anodo=4'b1110, segmentos=8'h03.
   - Edges 9-10: blank.
   - Edges 11-16: anodo=4'b1101, segmentos=8'h9F.
   - Then 4'b1011/8'h25 and 4'b0111/8'h0D in the same pattern.
   - Edge 33: frame_tick=1 again.
3. Tear-free latch:
   - Stimulus: change catodo3 to 8'h01 at edge 12 (during digit 1).
   - Frame 1, digit 2: still shows 8'h25.
   - Frame 2, digit 2: shows 8'h01.
4. Enable drop mid-slot:
   - Stimulus: enable=0 at edge 20.
   - From the next edge: anodo=4'b1111, segmentos=8'hFF, digito=0.
   - Stimulus: re-assert enable.
   - First enabled edge: frame_tick=1; digit 0 lights 2 cycles later.
5. Reset mid-frame: assert reset at edge 27 (digit 3 shown) -> next edge gives reset values and shadows=8'hFF. After release, scan restarts at digit 0.
6. Invariant check over 200 random-input cycles: anodo is never anything other than 4'b1111 or a single zero bit; every digit change is preceded by exactly 2 blank cycles.
